// File: rtl/ton_pow_nonce_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : ton_pow_nonce_sched_if
// Brief    : Host/job bus of the TON proof-of-work nonce scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface ton_pow_nonce_sched_if;
  logic [7:0]   i_job_data [123];
  logic [255:0] i_target;
  logic [63:0]  i_nonce_start;
  logic [31:0]  i_nonce_count;
  logic         i_start;
  logic         i_abort;
  logic         o_busy;
  logic         o_done;
  logic         o_found;
  logic [63:0]  o_nonce;
  logic [7:0]   o_hash [32];
  logic [31:0]  o_tried;

  modport master (
    output i_job_data, i_target, i_nonce_start, i_nonce_count, i_start, i_abort,
    input  o_busy, o_done, o_found, o_nonce, o_hash, o_tried
  );

  modport slave (
    input  i_job_data, i_target, i_nonce_start, i_nonce_count, i_start, i_abort,
    output o_busy, o_done, o_found, o_nonce, o_hash, o_tried
  );
endinterface
`default_nettype wire

// File: rtl/ton_pow_nonce_sched.sv
`default_nettype none
// ============================================================================
// Module   : sha256_1r_comb_core_v2 / ton_pow_nonce_sched
// Brief    : Single-block combinational SHA-256 compression core, and the
//            nonce sweep controller that runs 3 blocks per candidate through
//            it and compares the digest with a 256-bit target.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_1r_comb_core_v2 (
  input  logic [255:0] i_state,
  input  logic [511:0] i_block,
  output logic [255:0] o_state
);
  localparam logic [31:0] c_k [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] f_rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // 64 rounds unrolled; the message schedule lives in a rolling 16-word window
  function automatic logic [255:0] f_compress(input logic [255:0] st, input logic [511:0] blk);
    logic [31:0] w [16];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    s0 = '0;
    s1 = '0;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    {a, b, c, d, e, f, g, h} = st;
    for (int t = 0; t < 64; t++) begin
      if (t >= 16) begin
        s0 = f_rotr(w[4'(t-15)], 7) ^ f_rotr(w[4'(t-15)], 18) ^ (w[4'(t-15)] >> 3);
        s1 = f_rotr(w[4'(t-2)], 17) ^ f_rotr(w[4'(t-2)], 19) ^ (w[4'(t-2)] >> 10);
        w[4'(t)] = w[4'(t)] + s0 + w[4'(t-7)] + s1;
      end
      t1 = h + (f_rotr(e, 6) ^ f_rotr(e, 11) ^ f_rotr(e, 25)) + ((e & f) ^ (~e & g)) + c_k[t] + w[4'(t)];
      t2 = (f_rotr(a, 2) ^ f_rotr(a, 13) ^ f_rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {st[255:224] + a, st[223:192] + b, st[191:160] + c, st[159:128] + d,
            st[127:96] + e,  st[95:64] + f,   st[63:32] + g,   st[31:0] + h};
  endfunction

  assign o_state = f_compress(i_state, i_block);
endmodule

module ton_pow_nonce_sched #(
  parameter int NONCE_OFS    = 8,
  parameter bit STOP_ON_FIND = 1'b1
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  ton_pow_nonce_sched_if.slave        host
);
  localparam logic [255:0] c_iv = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  typedef enum logic [2:0] {S_IDLE, S_B0, S_B1, S_B2, S_CHK, S_DONE} state_t;

  state_t       r_state;
  logic [7:0]   r_job [123];
  logic [255:0] r_target;
  logic [63:0]  r_nonce;
  logic [31:0]  r_remaining;
  logic [255:0] r_mid;
  logic         r_busy, r_done, r_found;
  logic [63:0]  r_nonce_out;
  logic [255:0] r_hash;
  logic [31:0]  r_tried;

  logic [7:0]   w_msg [192];
  logic [511:0] w_block;
  logic [255:0] w_core_in, w_core_out;
  logic         w_hit, w_found_next, w_last;

  // Padded 3-block message: latched job with the nonce spliced in big-endian
  always_comb begin
    for (int i = 0; i < 123; i++) w_msg[i] = r_job[i];
    for (int i = 123; i < 192; i++) w_msg[i] = 8'h00;
    for (int i = 0; i < 8; i++) w_msg[NONCE_OFS + i] = r_nonce[63 - 8*i -: 8];
    w_msg[123] = 8'h80;
    w_msg[190] = 8'h03;
    w_msg[191] = 8'hD8;
  end

  // Block currently fed to the core, chosen by the round state
  always_comb begin
    w_block = '0;
    for (int i = 0; i < 64; i++) begin
      w_block[511 - 8*i -: 8] = (r_state == S_B1) ? w_msg[64 + i] :
                                (r_state == S_B2) ? w_msg[128 + i] : w_msg[i];
    end
  end

  assign w_core_in    = (r_state == S_B0) ? c_iv : r_mid;
  assign w_hit        = (r_mid < r_target);
  assign w_found_next = r_found | w_hit;
  assign w_last       = (r_remaining == 32'd1);

  sha256_1r_comb_core_v2 u_core (
    .i_state (w_core_in),
    .i_block (w_block),
    .o_state (w_core_out)
  );

  // Search operands are captured once, when a start is accepted
  always_ff @(posedge i_clk) begin
    if (r_state == S_IDLE && host.i_start) begin
      r_job    <= host.i_job_data;
      r_target <= host.i_target;
    end
  end

  // Sweep sequencer: three compressions then a compare per nonce
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_nonce     <= '0;
      r_remaining <= '0;
      r_mid       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_found     <= 1'b0;
      r_nonce_out <= '0;
      r_hash      <= '0;
      r_tried     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (host.i_start) begin
            r_nonce     <= host.i_nonce_start;
            r_remaining <= host.i_nonce_count;
            r_found     <= 1'b0;
            r_tried     <= '0;
            r_nonce_out <= '0;
            r_hash      <= '0;
            if (host.i_nonce_count == 32'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_B0;
              r_busy  <= 1'b1;
            end
          end
        end
        S_B0, S_B1, S_B2: begin
          if (host.i_abort) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_mid   <= w_core_out;
            r_state <= (r_state == S_B0) ? S_B1 : (r_state == S_B1) ? S_B2 : S_CHK;
          end
        end
        S_CHK: begin
          r_tried <= r_tried + 32'd1;
          // Until the first hit, results track the most recent checked nonce
          if (!r_found) begin
            r_found     <= w_hit;
            r_nonce_out <= r_nonce;
            r_hash      <= r_mid;
          end
          if (host.i_abort || (w_found_next && STOP_ON_FIND) || w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_nonce     <= r_nonce + 64'd1;
            r_remaining <= r_remaining - 32'd1;
            r_state     <= S_B0;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign host.o_busy  = r_busy;
  assign host.o_done  = r_done;
  assign host.o_found = r_found;
  assign host.o_nonce = r_nonce_out;
  assign host.o_tried = r_tried;

  for (genvar g = 0; g < 32; g++) begin : g_hash
    assign host.o_hash[g] = r_hash[255 - 8*g -: 8];
  end
endmodule
`default_nettype wire

// File: tb/tb_ton_pow_nonce_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_ton_pow_nonce_sched
// Brief    : Self-checking bench for ton_pow_nonce_sched with a software
//            SHA-256 reference and a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ton_pow_nonce_sched;
  localparam logic [31:0] c_k [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] c_iv = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  typedef struct {
    bit          use_b;
    int          seed;
    bit          tgt_ones;
    logic [63:0] start;
    logic [31:0] cnt;
    int          abort_at;
    bit          poke;
    bit          start_in_done;
    int          exp_done;
    logic [31:0] exp_tried;
    bit          exp_found;
  } vec_t;

  typedef struct {
    int           done_cyc;
    bit           found;
    logic [31:0]  tried;
    logic [63:0]  nonce;
    logic [255:0] hash;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b, abort, sel;
  logic [7:0]   tb_job [123];
  logic [255:0] tb_target;
  logic [63:0]  tb_start_n;
  logic [31:0]  tb_count;
  logic         s_busy, s_done, s_found;
  logic [63:0]  s_nonce;
  logic [31:0]  s_tried;
  logic [255:0] s_hash;
  int n_checks = 0;
  int n_fail = 0;
  exp_t sb [$];

  always #5 clk = ~clk;

  ton_pow_nonce_sched_if bus_a ();
  ton_pow_nonce_sched_if bus_b ();

  assign bus_a.i_job_data = tb_job;    assign bus_b.i_job_data = tb_job;
  assign bus_a.i_target = tb_target;   assign bus_b.i_target = tb_target;
  assign bus_a.i_nonce_start = tb_start_n; assign bus_b.i_nonce_start = tb_start_n;
  assign bus_a.i_nonce_count = tb_count;   assign bus_b.i_nonce_count = tb_count;
  assign bus_a.i_abort = abort;        assign bus_b.i_abort = abort;
  assign bus_a.i_start = start_a;      assign bus_b.i_start = start_b;

  ton_pow_nonce_sched #(.NONCE_OFS(8), .STOP_ON_FIND(1'b1)) u_dut_a (
    .i_clk(clk), .i_reset(rst), .host(bus_a.slave));
  ton_pow_nonce_sched #(.NONCE_OFS(115), .STOP_ON_FIND(1'b0)) u_dut_b (
    .i_clk(clk), .i_reset(rst), .host(bus_b.slave));

  always_comb begin
    s_busy  = sel ? bus_b.o_busy  : bus_a.o_busy;
    s_done  = sel ? bus_b.o_done  : bus_a.o_done;
    s_found = sel ? bus_b.o_found : bus_a.o_found;
    s_nonce = sel ? bus_b.o_nonce : bus_a.o_nonce;
    s_tried = sel ? bus_b.o_tried : bus_a.o_tried;
    s_hash  = '0;
    for (int i = 0; i < 32; i++) s_hash[255 - 8*i -: 8] = sel ? bus_b.o_hash[i] : bus_a.o_hash[i];
  end

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook compression: full 64-word schedule first, then the rounds
  function automatic logic [255:0] sw_compress(input logic [255:0] st, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] hv [8];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7] +
             (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int i = 0; i < 8; i++) hv[i] = st[255 - 32*i -: 32];
    a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3]; e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
    for (int t = 0; t < 64; t++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + c_k[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hv[0] + a, hv[1] + b, hv[2] + c, hv[3] + d, hv[4] + e, hv[5] + f, hv[6] + g, hv[7] + h};
  endfunction

  function automatic logic [255:0] sw_pow(input logic [7:0] job [123], input logic [63:0] nonce, input int ofs);
    logic [7:0] m [192];
    logic [511:0] blk;
    logic [255:0] st;
    for (int i = 0; i < 192; i++) m[i] = (i < 123) ? job[i] : 8'h00;
    for (int i = 0; i < 8; i++) m[ofs + i] = nonce[63 - 8*i -: 8];
    m[123] = 8'h80; m[190] = 8'h03; m[191] = 8'hD8;
    st = c_iv;
    for (int bk = 0; bk < 3; bk++) begin
      for (int i = 0; i < 64; i++) blk[511 - 8*i -: 8] = m[64*bk + i];
      st = sw_compress(st, blk);
    end
    return st;
  endfunction

  // Reference search: which nonce/digest the result registers should hold
  function automatic void model_run(input logic [7:0] job [123], input logic [255:0] tgt,
                                    input logic [63:0] st, input logic [31:0] cnt, input int ofs,
                                    input bit stop, input int abort_at,
                                    output logic [63:0] n_o, output logic [255:0] h_o);
    bit fnd;
    logic [255:0] dg;
    fnd = 1'b0; n_o = '0; h_o = '0;
    for (int k = 0; k < int'(cnt); k++) begin
      if (abort_at > 0 && abort_at < 4*k + 4) break;
      dg = sw_pow(job, st + 64'(k), ofs);
      if (!fnd) begin n_o = st + 64'(k); h_o = dg; fnd = (dg < tgt); end
      if (fnd && stop) break;
    end
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fill_job(input int seed);
    for (int i = 0; i < 123; i++) tb_job[i] = (seed == 0) ? 8'h00 : 8'(seed*53 + i*7 + i*i);
  endtask

  // Called at a negedge while the selected DUT is idle; returns at a negedge in IDLE
  task automatic run_vec(input string tag, input bit use_b, input logic [255:0] tgt,
                         input logic [63:0] st, input logic [31:0] cnt, input int abort_at,
                         input bit poke, input bit start_in_done, input int exp_done,
                         input logic [31:0] exp_tried, input bit exp_found);
    exp_t e;
    logic [63:0] mn;
    logic [255:0] mh;
    int cyc;
    bit seen, busy_ok;
    model_run(tb_job, tgt, st, cnt, use_b ? 115 : 8, !use_b, abort_at, mn, mh);
    e = '{exp_done, exp_found, exp_tried, mn, mh};
    sb.push_back(e);
    sel = use_b; tb_target = tgt; tb_start_n = st; tb_count = cnt;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    if (poke) begin
      for (int i = 0; i < 123; i++) tb_job[i] = ~tb_job[i];
      tb_target = ~tgt; tb_start_n = ~st; tb_count = 32'd7;
    end
    cyc = 0; seen = 1'b0; busy_ok = 1'b1;
    while (!seen && cyc < 600) begin
      @(negedge clk);
      cyc++;
      abort = (abort_at == cyc);
      if (poke) begin
        if (use_b) start_b = (cyc == 2); else start_a = (cyc == 2);
      end
      if (s_done) begin
        seen = 1'b1;
        check({tag, " busy_in_done"}, 256'(s_busy), 256'(0));
      end else if (!s_busy) busy_ok = 1'b0;
    end
    abort = 1'b0; start_a = 1'b0; start_b = 1'b0;
    e = sb.pop_front();
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL %s timeout: got no done in %0d cycles, expected done at cycle %0d", tag, cyc, e.done_cyc);
    end else begin
      check({tag, " done_cycle"}, 256'(cyc), 256'(e.done_cyc));
      check({tag, " busy_window"}, 256'(busy_ok), 256'(1));
      check({tag, " found"}, 256'(s_found), 256'(e.found));
      check({tag, " tried"}, 256'(s_tried), 256'(e.tried));
      check({tag, " nonce"}, 256'(s_nonce), 256'(e.nonce));
      check({tag, " hash"}, s_hash, e.hash);
      if (start_in_done) begin
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
      end
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
      check({tag, " done_pulse"}, 256'(s_done), 256'(0));
      check({tag, " idle_busy"}, 256'(s_busy), 256'(0));
      check({tag, " nonce_hold"}, 256'(s_nonce), 256'(e.nonce));
    end
  endtask

  initial begin
    vec_t vt [6];
    logic [255:0] dg [5];
    logic [255:0] mx, tgt24;
    bit ok;
    int bad;

    vt[0] = '{1'b0, 0, 1'b0, 64'h0123456789ABCDEF, 32'd1,  0, 1'b0, 1'b0, 5,  32'd1, 1'b0};
    vt[1] = '{1'b0, 1, 1'b1, 64'h0000000000001000, 32'd100, 0, 1'b0, 1'b1, 5,  32'd1, 1'b1};
    vt[2] = '{1'b0, 2, 1'b0, 64'hFFFFFFFFFFFFFFFE, 32'd3,  0, 1'b0, 1'b0, 13, 32'd3, 1'b0};
    vt[3] = '{1'b0, 0, 1'b0, 64'h0000000000000055, 32'd0,  0, 1'b0, 1'b0, 1,  32'd0, 1'b0};
    vt[4] = '{1'b1, 4, 1'b1, 64'h0000000000000005, 32'd3,  0, 1'b1, 1'b0, 13, 32'd3, 1'b1};
    vt[5] = '{1'b0, 3, 1'b0, 64'h000000000000ABCD, 32'd50, 6, 1'b1, 1'b0, 7,  32'd1, 1'b0};

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; abort = 1'b0; sel = 1'b0;
    tb_target = '0; tb_start_n = '0; tb_count = '0;
    fill_job(0);

    check("model_kat_abc", sw_compress(c_iv, {32'h61626380, 448'h0, 32'h00000018}),
          256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset busy",  256'(s_busy),  256'(0));
    check("reset done",  256'(s_done),  256'(0));
    check("reset found", 256'(s_found), 256'(0));
    check("reset tried", 256'(s_tried), 256'(0));
    check("reset nonce", 256'(s_nonce), 256'(0));
    check("reset hash",  s_hash, 256'(0));

    for (int v = 0; v < 6; v++) begin
      fill_job(vt[v].seed);
      run_vec($sformatf("vec%0d", v), vt[v].use_b, vt[v].tgt_ones ? {256{1'b1}} : 256'(0),
              vt[v].start, vt[v].cnt, vt[v].abort_at, vt[v].poke, vt[v].start_in_done,
              vt[v].exp_done, vt[v].exp_tried, vt[v].exp_found);
    end

    // Reset in the middle of a search on instance B
    sel = 1'b1; fill_job(9); tb_target = '0; tb_start_n = 64'd0; tb_count = 32'd10;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst busy_before", 256'(s_busy), 256'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy",  256'(s_busy),  256'(0));
    check("midrst done",  256'(s_done),  256'(0));
    check("midrst found", 256'(s_found), 256'(0));
    check("midrst tried", 256'(s_tried), 256'(0));
    check("midrst nonce", 256'(s_nonce), 256'(0));
    check("midrst hash",  s_hash, 256'(0));
    sel = 1'b0;
    check("midrst a_tried", 256'(s_tried), 256'(0));
    check("midrst a_nonce", 256'(s_nonce), 256'(0));
    sel = 1'b1;
    bad = 0;
    repeat (45) begin
      @(negedge clk);
      if (s_done || s_busy) bad++;
    end
    check("midrst quiet", 256'(bad), 256'(0));

    // Pick a job where, of nonces 0..4, only 2 and 4 fall below the target
    ok = 1'b0; tgt24 = '0;
    for (int s = 100; s < 400 && !ok; s++) begin
      fill_job(s);
      for (int k = 0; k < 5; k++) dg[k] = sw_pow(tb_job, 64'(k), 115);
      mx = (dg[2] > dg[4]) ? dg[2] : dg[4];
      if (dg[0] > mx && dg[1] > mx && dg[3] > mx) begin ok = 1'b1; tgt24 = mx + 256'd1; end
    end
    check("hit24 job_search", 256'(ok), 256'(1));
    if (ok) begin
      run_vec("hit24", 1'b1, tgt24, 64'd0, 32'd5, 0, 1'b0, 1'b0, 21, 32'd5, 1'b1);
      check("hit24 first_nonce", 256'(s_nonce), 256'(2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
